// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// The cause encoding ranks the RUN-state hazard sources from highest to lowest priority.
package hazard_pkg;

    typedef enum logic {
        ST_RUN       = 1'b0,
        ST_LONG_WAIT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        PRI_NONE     = 2'd0,
        PRI_REDIRECT = 2'd1,
        PRI_LOAD_USE = 2'd2,
        PRI_LONGOP   = 2'd3
    } pri_t;

    // Width of a counter that must reach timeout-1.
    function automatic int wait_w(input int timeout);
        return (timeout <= 2) ? 1 : $clog2(timeout);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side view of the hazard controller: decode/execute status in, stall controls out.
// The pipeline uses the master modport; the controller uses the slave modport.
interface hazard_ctrl_if #(
    parameter int REG_W = 5
);
    logic             memread_ex;
    logic [REG_W-1:0] rd_ex;
    logic [REG_W-1:0] rs_id;
    logic [REG_W-1:0] rt_id;
    logic             use_rs_id;
    logic             use_rt_id;
    logic             redirect_ex;
    logic             longop_id;
    logic             longop_done;
    logic             hazard;
    logic             pcwrite;
    logic             ifid_write;
    logic             ifid_flush;

    modport master (
        output memread_ex, rd_ex, rs_id, rt_id, use_rs_id, use_rt_id,
               redirect_ex, longop_id, longop_done,
        input  hazard, pcwrite, ifid_write, ifid_flush
    );

    modport slave (
        input  memread_ex, rd_ex, rs_id, rt_id, use_rs_id, use_rt_id,
               redirect_ex, longop_id, longop_done,
        output hazard, pcwrite, ifid_write, ifid_flush
    );
endinterface

// File: rtl/hazard_lu_cmp.sv
// Load-use detector: the EX load writes a register the ID instruction actually reads.
// Register 0 is hardwired to zero, so it never creates a dependency.
module hazard_lu_cmp #(
    parameter int REG_W = 5
) (
    input  logic             memread_ex,
    input  logic [REG_W-1:0] rd_ex,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             use_rs_id,
    input  logic             use_rt_id,
    output logic             lu
);
    logic rs_hit;
    logic rt_hit;

    assign rs_hit = use_rs_id && (rs_id == rd_ex);
    assign rt_hit = use_rt_id && (rt_id == rd_ex);
    assign lu     = memread_ex && (rd_ex != '0) && (rs_hit || rt_hit);
endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, EX redirect flushes and multi-cycle op waits,
// with a sticky timeout flag and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    hazard_ctrl_if.slave     bus,
    output logic             err_timeout,
    output logic [CNT_W-1:0] stall_cnt
);
    localparam int                WAIT_W    = wait_w(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nxt;
    pri_t              pri;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_clr;
    logic              timeout_hit;
    logic              lu;

    hazard_lu_cmp #(
        .REG_W (REG_W)
    ) u_lu_cmp (
        .memread_ex (bus.memread_ex),
        .rd_ex      (bus.rd_ex),
        .rs_id      (bus.rs_id),
        .rt_id      (bus.rt_id),
        .use_rs_id  (bus.use_rs_id),
        .use_rt_id  (bus.use_rt_id),
        .lu         (lu)
    );

    always_comb begin
        pri = PRI_NONE;
        if (bus.redirect_ex)    pri = PRI_REDIRECT;
        else if (lu)            pri = PRI_LOAD_USE;
        else if (bus.longop_id) pri = PRI_LONGOP;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            err_timeout <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (wait_clr)
                wait_cnt <= '0;
            else if (state == ST_LONG_WAIT)
                wait_cnt <= wait_cnt + 1'b1;
            if (timeout_hit)
                err_timeout <= 1'b1;
            if (!bus.pcwrite && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    always_comb begin
        state_nxt      = state;
        wait_clr       = 1'b0;
        timeout_hit    = 1'b0;
        bus.hazard     = 1'b0;
        bus.pcwrite    = 1'b1;
        bus.ifid_write = 1'b1;
        bus.ifid_flush = 1'b0;

        unique case (state)
            ST_RUN: begin
                unique case (pri)
                    // Redirect kills the ID instruction, so its hazards are moot.
                    PRI_REDIRECT: begin
                        bus.hazard     = 1'b1;
                        bus.ifid_flush = 1'b1;
                    end
                    PRI_LOAD_USE: begin
                        bus.hazard     = 1'b1;
                        bus.pcwrite    = 1'b0;
                        bus.ifid_write = 1'b0;
                    end
                    PRI_LONGOP: begin
                        state_nxt = ST_LONG_WAIT;
                        wait_clr  = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_LONG_WAIT: begin
                bus.hazard     = 1'b1;
                bus.pcwrite    = 1'b0;
                bus.ifid_write = 1'b0;
                if (bus.longop_done) begin
                    state_nxt = ST_RUN;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt   = ST_RUN;
                    timeout_hit = 1'b1;
                end
            end
            default: state_nxt = ST_RUN;
        endcase

        if (rst) begin
            bus.hazard     = 1'b1;
            bus.pcwrite    = 1'b0;
            bus.ifid_write = 1'b0;
            bus.ifid_flush = 1'b1;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: load-use, x0/unused operands, redirect priority,
// long-op wait, timeout, saturation and reset during a long-op wait.
module tb_hazard_ctrl;
    localparam int REG_W   = 5;
    localparam int TIMEOUT = 8;
    localparam int CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             err_timeout;
    logic [CNT_W-1:0] stall_cnt;

    int n_checks = 0;
    int n_errors = 0;

    hazard_ctrl_if #(.REG_W(REG_W)) bus ();

    hazard_ctrl #(
        .REG_W   (REG_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .err_timeout (err_timeout),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Combinational outputs settle #1 after inputs change; packed as {hazard,pcwrite,ifid_write,ifid_flush}.
    task automatic chk_ctl(input string tag, input logic [3:0] exp);
        #1;
        chk(tag, {bus.hazard, bus.pcwrite, bus.ifid_write, bus.ifid_flush}, {28'd0, exp});
    endtask

    task automatic clear_inputs();
        bus.memread_ex  = 1'b0;
        bus.rd_ex       = '0;
        bus.rs_id       = '0;
        bus.rt_id       = '0;
        bus.use_rs_id   = 1'b0;
        bus.use_rt_id   = 1'b0;
        bus.redirect_ex = 1'b0;
        bus.longop_id   = 1'b0;
        bus.longop_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    localparam logic [3:0] C_RUN   = 4'b0110;
    localparam logic [3:0] C_STALL = 4'b1000;
    localparam logic [3:0] C_FLUSH = 4'b1111;
    localparam logic [3:0] C_RST   = 4'b1001;

    initial begin
        clear_inputs();
        rst = 1'b1;
        #2;
        chk_ctl("rst_forced", C_RST);
        step();
        step();
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_err", err_timeout, 0);
        rst = 1'b0;
        step();
        chk_ctl("run_idle", C_RUN);
        chk("idle_stall_cnt", stall_cnt, 0);

        // T1 load-use on rs
        bus.memread_ex = 1'b1; bus.rd_ex = 5'd5; bus.rs_id = 5'd5; bus.use_rs_id = 1'b1;
        chk_ctl("t1_lu_stall", C_STALL);
        step();
        clear_inputs();
        chk_ctl("t1_after", C_RUN);
        chk("t1_stall_cnt", stall_cnt, 1);

        // T2 x0 destination and unused operand
        bus.memread_ex = 1'b1; bus.rd_ex = 5'd0; bus.rs_id = 5'd0; bus.use_rs_id = 1'b1;
        chk_ctl("t2_x0", C_RUN);
        bus.rd_ex = 5'd7; bus.rs_id = 5'd3; bus.rt_id = 5'd7; bus.use_rt_id = 1'b0;
        chk_ctl("t2_rt_unused", C_RUN);
        bus.use_rt_id = 1'b1;
        chk_ctl("t2_rt_used", C_STALL);
        step();
        clear_inputs();
        chk("t2_stall_cnt", stall_cnt, 2);

        // T3 redirect outranks load-use and long op
        bus.redirect_ex = 1'b1; bus.memread_ex = 1'b1; bus.rd_ex = 5'd5;
        bus.rs_id = 5'd5; bus.use_rs_id = 1'b1; bus.longop_id = 1'b1;
        chk_ctl("t3_redirect", C_FLUSH);
        step();
        clear_inputs();
        chk_ctl("t3_no_longwait", C_RUN);
        chk("t3_stall_cnt", stall_cnt, 2);

        // T4 long op, done four cycles after issue; redirect inside the wait is ignored
        do_reset();
        bus.longop_id = 1'b1;
        chk_ctl("t4_issue", C_RUN);
        step();
        bus.longop_id = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            bus.redirect_ex = (k == 2);
            bus.longop_done = (k == 4);
            chk_ctl($sformatf("t4_wait%0d", k), C_STALL);
            step();
        end
        clear_inputs();
        chk_ctl("t4_back_run", C_RUN);
        chk("t4_stall_cnt", stall_cnt, 4);
        bus.longop_done = 1'b1;
        chk_ctl("t4_done_in_run", C_RUN);
        step();
        clear_inputs();
        chk("t4_stall_cnt_hold", stall_cnt, 4);

        // Minimum occupancy: done the cycle after issue
        bus.longop_id = 1'b1;
        step();
        bus.longop_id = 1'b0; bus.longop_done = 1'b1;
        chk_ctl("min_wait", C_STALL);
        step();
        clear_inputs();
        chk_ctl("min_back_run", C_RUN);
        chk("min_stall_cnt", stall_cnt, 5);

        // T5 timeout after TIMEOUT cycles, sticky flag, counter saturation
        do_reset();
        bus.longop_id = 1'b1;
        step();
        bus.longop_id = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) begin
            chk_ctl($sformatf("t5_wait%0d", k), C_STALL);
            chk($sformatf("t5_err_pre%0d", k), err_timeout, 0);
            step();
        end
        chk_ctl("t5_exit", C_RUN);
        chk("t5_err", err_timeout, 1);
        chk("t5_stall_cnt", stall_cnt, TIMEOUT);
        step();
        step();
        chk("t5_err_sticky", err_timeout, 1);
        bus.longop_id = 1'b1;
        step();
        bus.longop_id = 1'b0;
        for (int k = 1; k <= TIMEOUT; k++) step();
        chk_ctl("t5_exit2", C_RUN);
        chk("t5_saturate", stall_cnt, 15);
        chk("t5_err_sticky2", err_timeout, 1);

        // T6 reset while waiting at wait_cnt=3, then a stray done
        do_reset();
        chk("t6_err_cleared", err_timeout, 0);
        bus.longop_id = 1'b1;
        step();
        bus.longop_id = 1'b0;
        step();
        step();
        step();
        chk("t6_pre_cnt", stall_cnt, 3);
        rst = 1'b1;
        chk_ctl("t6_rst_forced", C_RST);
        step();
        rst = 1'b0;
        chk("t6_cnt_zero", stall_cnt, 0);
        chk_ctl("t6_run", C_RUN);
        bus.longop_done = 1'b1;
        chk_ctl("t6_stray_done", C_RUN);
        step();
        clear_inputs();
        chk_ctl("t6_still_run", C_RUN);
        chk("t6_cnt_final", stall_cnt, 0);
        chk("t6_err_final", err_timeout, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
